// File: rtl/pmem_arbiter_if.sv
// Cache-side and adaptor-side bus of the pmem arbiter.
// slave = the arbiter's view, master = the caches plus cacheline adaptor.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BE_W   = LINE_W / 8
);
  // I-cache port
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // D-cache port
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_enable;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // Cacheline adaptor port
  logic              ca_read;
  logic              ca_write;
  logic [ADDR_W-1:0] ca_addr;
  logic [LINE_W-1:0] ca_wdata;
  logic [BE_W-1:0]   ca_byte_enable;
  logic [LINE_W-1:0] ca_rdata;
  logic              ca_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable,
    input  ca_rdata, ca_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output ca_read, ca_write, ca_addr, ca_wdata, ca_byte_enable
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_byte_enable,
    output ca_rdata, ca_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  ca_read, ca_write, ca_addr, ca_wdata, ca_byte_enable
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one cacheline adaptor between the I-cache and D-cache, one whole-line
// transaction at a time. Define PMEM_ARB_RR_EN for round-robin ties; default is D-cache priority.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BE_W   = LINE_W / 8
) (
  input  logic            clk,
  input  logic            rst,
  pmem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t            state;
  logic              ca_read_q;
  logic              ca_write_q;
  logic [ADDR_W-1:0] ca_addr_q;
  logic [LINE_W-1:0] ca_wdata_q;
  logic [BE_W-1:0]   ca_be_q;
  logic [LINE_W-1:0] line_q;
  logic              i_resp_q;
  logic              d_resp_q;

  logic i_pend;
  logic d_pend;
  logic grant_d;

  assign i_pend = bus.i_read;
  assign d_pend = bus.d_read | bus.d_write;

`ifdef PMEM_ARB_RR_EN
  logic last_d;  // 1 when the D-cache received the most recent grant
  assign grant_d = d_pend & (~i_pend | ~last_d);
`else
  assign grant_d = d_pend;
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the pre-edge values.
    if (!rst) begin
      // NOTE: the wide address/data/line registers are reset on purpose: their
      // outputs are visible to the caches and must read zero out of reset.
      state      <= IDLE;
      ca_read_q  <= 1'b0;
      ca_write_q <= 1'b0;
      ca_addr_q  <= '0;
      ca_wdata_q <= '0;
      ca_be_q    <= '0;
      line_q     <= '0;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
`ifdef PMEM_ARB_RR_EN
      last_d     <= 1'b1;
`endif
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= BUSY_D;
            ca_addr_q  <= bus.d_addr;
            ca_wdata_q <= bus.d_wdata;
            ca_be_q    <= bus.d_byte_enable;
            // A simultaneous read+write is treated as a write-back.
            ca_write_q <= bus.d_write;
            ca_read_q  <= ~bus.d_write;
`ifdef PMEM_ARB_RR_EN
            last_d     <= 1'b1;
`endif
          end else if (i_pend) begin
            state      <= BUSY_I;
            ca_addr_q  <= bus.i_addr;
            ca_wdata_q <= '0;
            ca_be_q    <= '0;
            ca_write_q <= 1'b0;
            ca_read_q  <= 1'b1;
`ifdef PMEM_ARB_RR_EN
            last_d     <= 1'b0;
`endif
          end
        end

        BUSY_I, BUSY_D: begin
          if (bus.ca_resp) begin
            line_q     <= bus.ca_rdata;
            ca_read_q  <= 1'b0;
            ca_write_q <= 1'b0;
            i_resp_q   <= (state == BUSY_I);
            d_resp_q   <= (state == BUSY_D);
            state      <= (state == BUSY_I) ? DONE_I : DONE_D;
          end
        end

        DONE_I, DONE_D: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // One shared line register feeds both caches; only the resp pulse differs.
  assign bus.i_rdata        = line_q;
  assign bus.d_rdata        = line_q;
  assign bus.i_resp         = i_resp_q;
  assign bus.d_resp         = d_resp_q;
  assign bus.ca_read        = ca_read_q;
  assign bus.ca_write       = ca_write_q;
  assign bus.ca_addr        = ca_addr_q;
  assign bus.ca_wdata       = ca_wdata_q;
  assign bus.ca_byte_enable = ca_be_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed table, random traffic against a
// grant-rule model, and hand sequences for ties, reset mid-transaction and stray responses.
module tb_pmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BE_W   = LINE_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BE_W-1:0]   be_t;

  typedef struct {
    string name;
    logic  ir, dr, dw;
    addr_t ia, da;
    line_t wd;
    be_t   be;
    int    k;
    line_t rd;
    logic  exp_d, exp_wr;
    addr_t exp_addr;
    line_t exp_wdata;
    be_t   exp_be;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  bit    model_last_d;
  line_t model_line;
  vec_t  vecs[5];

  task automatic check(input string name, input line_t act, input line_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Which port the grant rules pick for a given pending set (caller ensures one is pending).
  function automatic bit model_pick_d(input bit ip, input bit dp);
    if (!dp) return 1'b0;
    if (!ip) return 1'b1;
`ifdef PMEM_ARB_RR_EN
    return !model_last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_inputs();
    bus.i_read = 1'b0;  bus.i_addr = '0;
    bus.d_read = 1'b0;  bus.d_write = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0;   bus.d_byte_enable = '0;
    bus.ca_rdata = '0;  bus.ca_resp = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_b({tag, ".ca_read"},  bus.ca_read,  1'b0);
    check_b({tag, ".ca_write"}, bus.ca_write, 1'b0);
    check_b({tag, ".i_resp"},   bus.i_resp,   1'b0);
    check_b({tag, ".d_resp"},   bus.d_resp,   1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    check_quiet("reset");
    check("reset.ca_addr",  256'(bus.ca_addr),        '0);
    check("reset.ca_wdata", bus.ca_wdata,             '0);
    check("reset.ca_be",    256'(bus.ca_byte_enable), '0);
    check("reset.i_rdata",  bus.i_rdata,              '0);
    check("reset.d_rdata",  bus.d_rdata,              '0);
    tick();
    rst = 1'b1;
    model_last_d = 1'b1;
    model_line   = '0;
  endtask

  // Starts in an IDLE cycle with requests already driven; returns in the IDLE cycle after resp.
  task automatic run_txn(input string tag, input bit win_d, input bit exp_wr,
                         input addr_t exp_addr, input line_t exp_wdata, input be_t exp_be,
                         input int k, input line_t rdata);
    bus.ca_resp = 1'b0;
    @(negedge clk);
    check_quiet({tag, ".idle"});
    tick();
    for (int c = 1; c <= k; c++) begin
      bus.ca_resp  = (c == k);
      bus.ca_rdata = (c == k) ? rdata : rand_line();
      // The captured command must not follow the requester's inputs while busy.
      if (win_d) begin
        bus.d_addr = $urandom; bus.d_wdata = rand_line(); bus.d_byte_enable = $urandom;
      end else begin
        bus.i_addr = $urandom;
      end
      @(negedge clk);
      check_b({tag, ".ca_read"},  bus.ca_read,  !exp_wr);
      check_b({tag, ".ca_write"}, bus.ca_write, exp_wr);
      check({tag, ".ca_addr"},  256'(bus.ca_addr),        256'(exp_addr));
      check({tag, ".ca_wdata"}, bus.ca_wdata,             exp_wdata);
      check({tag, ".ca_be"},    256'(bus.ca_byte_enable), 256'(exp_be));
      check_b({tag, ".busy_i_resp"}, bus.i_resp, 1'b0);
      check_b({tag, ".busy_d_resp"}, bus.d_resp, 1'b0);
      tick();
    end
    bus.ca_resp  = 1'b0;
    bus.ca_rdata = rand_line();
    model_line   = rdata;
    model_last_d = win_d;
    @(negedge clk);
    check_b({tag, ".i_resp"},     bus.i_resp,   !win_d);
    check_b({tag, ".d_resp"},     bus.d_resp,   win_d);
    check({tag, ".i_rdata"},      bus.i_rdata,  model_line);
    check({tag, ".d_rdata"},      bus.d_rdata,  model_line);
    check_b({tag, ".done_read"},  bus.ca_read,  1'b0);
    check_b({tag, ".done_write"}, bus.ca_write, 1'b0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ip, dp, drd, dwr, wd;
    addr_t ia, da;
    line_t dwd;
    be_t   dbe;
    bit    order[4];

    vecs[0] = '{name:"i_only", ir:1, dr:0, dw:0, ia:32'h0000_1000, da:32'h7777_0000,
                wd:{8{32'h55AA_55AA}}, be:32'hFFFF_FFFF, k:3, rd:{32{8'hA5}},
                exp_d:0, exp_wr:0, exp_addr:32'h0000_1000, exp_wdata:'0, exp_be:'0};
    vecs[1] = '{name:"d_wb", ir:0, dr:0, dw:1, ia:32'h0, da:32'h0000_2000,
                wd:{8{32'h1234_5678}}, be:32'hFFFF_FFFF, k:1, rd:{8{32'hFEED_FACE}},
                exp_d:1, exp_wr:1, exp_addr:32'h0000_2000, exp_wdata:{8{32'h1234_5678}},
                exp_be:32'hFFFF_FFFF};
    vecs[2] = '{name:"d_rd", ir:0, dr:1, dw:0, ia:32'h0, da:32'h0000_3040,
                wd:{8{32'h1357_9BDF}}, be:32'h0000_FFFF, k:2, rd:{8{32'hDEAD_BEEF}},
                exp_d:1, exp_wr:0, exp_addr:32'h0000_3040, exp_wdata:{8{32'h1357_9BDF}},
                exp_be:32'h0000_FFFF};
    vecs[3] = '{name:"d_rdwr", ir:0, dr:1, dw:1, ia:32'h0, da:32'h0000_4000,
                wd:{8{32'hCAFE_F00D}}, be:32'h0F0F_00FF, k:2, rd:{8{32'h0123_4567}},
                exp_d:1, exp_wr:1, exp_addr:32'h0000_4000, exp_wdata:{8{32'hCAFE_F00D}},
                exp_be:32'h0F0F_00FF};
    vecs[4] = '{name:"i_k1", ir:1, dr:0, dw:0, ia:32'hFFFF_FFE0, da:32'h0000_9999,
                wd:{8{32'h8888_7777}}, be:32'h00FF_FF00, k:1, rd:{16{16'h5A3C}},
                exp_d:0, exp_wr:0, exp_addr:32'hFFFF_FFE0, exp_wdata:'0, exp_be:'0};

    do_reset();

    // Directed single-requester transactions.
    foreach (vecs[v]) begin
      bus.i_read = vecs[v].ir;  bus.i_addr = vecs[v].ia;
      bus.d_read = vecs[v].dr;  bus.d_write = vecs[v].dw;
      bus.d_addr = vecs[v].da;  bus.d_wdata = vecs[v].wd;
      bus.d_byte_enable = vecs[v].be;
      run_txn(vecs[v].name, vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_addr,
              vecs[v].exp_wdata, vecs[v].exp_be, vecs[v].k, vecs[v].rd);
      bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    end

    // Random traffic; a losing requester stays pending with the same command.
    ip = 0; dp = 0; drd = 0; dwr = 0; ia = '0; da = '0; dwd = '0; dbe = '0;
    for (int it = 0; it < 40; it++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = $urandom; dwd = rand_line(); dbe = $urandom;
        case ($urandom_range(0, 2))
          0:       {drd, dwr} = 2'b10;
          1:       {drd, dwr} = 2'b01;
          default: {drd, dwr} = 2'b11;
        endcase
      end
      bus.i_read = ip;       bus.i_addr = ia;
      bus.d_read = dp & drd; bus.d_write = dp & dwr;
      bus.d_addr = da;       bus.d_wdata = dwd; bus.d_byte_enable = dbe;
      if (!ip && !dp) begin
        bus.ca_resp  = ($urandom_range(0, 1) == 1);
        bus.ca_rdata = rand_line();
        @(negedge clk);
        check_quiet("rnd_idle");
        tick();
        bus.ca_resp = 1'b0;
        continue;
      end
      wd = model_pick_d(ip, dp);
      if (wd) begin
        run_txn("rnd_d", 1'b1, dwr, da, dwd, dbe, $urandom_range(1, 4), rand_line());
        dp = 0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      end else begin
        run_txn("rnd_i", 1'b0, 1'b0, ia, '0, '0, $urandom_range(1, 4), rand_line());
        ip = 0; bus.i_read = 1'b0;
      end
    end

    // Ties from reset: both caches keep requesting after every resp.
    do_reset();
`ifdef PMEM_ARB_RR_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    for (int t = 0; t < 4; t++) begin
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_A000 + 32'(t * 64);
      bus.d_addr = 32'h0000_B000 + 32'(t * 64);
      bus.d_wdata = '0; bus.d_byte_enable = '0;
`ifdef PMEM_ARB_RR_EN
      bus.d_read = 1'b1;
`else
      bus.d_read = (t < 3);
`endif
      run_txn(order[t] ? "tie_d" : "tie_i", order[t], 1'b0,
              order[t] ? 32'h0000_B000 + 32'(t * 64) : 32'h0000_A000 + 32'(t * 64),
              '0, '0, 2, {8{32'h7000_0000 + 32'(t)}});
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;

    // Reset in the middle of a D read: commands drop, no resp, then a clean retry.
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_5000;
    bus.d_wdata = {8{32'h0BAD_F00D}}; bus.d_byte_enable = 32'hFFFF_0000;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_b("rst_mid.busy", bus.ca_read, 1'b1);
    tick();
    bus.d_read = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid.after");
    check("rst_mid.ca_addr",  256'(bus.ca_addr),        '0);
    check("rst_mid.ca_wdata", bus.ca_wdata,             '0);
    check("rst_mid.ca_be",    256'(bus.ca_byte_enable), '0);
    check("rst_mid.d_rdata",  bus.d_rdata,              '0);
    tick();
    rst = 1'b1;
    model_last_d = 1'b1;
    model_line   = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet("rst_mid.quiet");
      tick();
    end
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_5040;
    bus.d_wdata = {8{32'h0BAD_F00D}}; bus.d_byte_enable = 32'hFFFF_0000;
    run_txn("rst_retry", 1'b1, 1'b0, 32'h0000_5040, {8{32'h0BAD_F00D}}, 32'hFFFF_0000,
            2, {8{32'h600D_CAFE}});
    bus.d_read = 1'b0;

    // Stray adaptor resp while idle: no resp and the line register keeps its value.
    bus.ca_resp  = 1'b1;
    bus.ca_rdata = ~model_line;
    @(negedge clk);
    check_quiet("stray.pulse");
    tick();
    bus.ca_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_quiet("stray.after");
      check("stray.i_rdata", bus.i_rdata, model_line);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
